// File: rtl/ecm_pkg.sv
// Shared ECM types and constants.
//   ecm_dds_control_t     : per-channel DDS programming word
//   channelizer_control_t : channelizer timing strobe (valid/last/data_index)
//   ecm_dds_mode_e        : DDS channel mode (off/tone/sweep)
package ecm_pkg;

  localparam int unsigned ecm_num_channels        = 8;
  localparam int unsigned ecm_channel_index_width = 8;
  localparam int unsigned ecm_dds_data_width      = 16;
  localparam int unsigned ecm_dds_phase_width     = 32;
  localparam int unsigned ecm_dds_lut_addr_width  = 12;

  typedef enum logic [1:0] {
    ecm_dds_mode_off   = 2'd0,
    ecm_dds_mode_tone  = 2'd1,
    ecm_dds_mode_sweep = 2'd2
  } ecm_dds_mode_e;

  typedef struct packed {
    logic                               valid;
    logic                               last;
    logic [ecm_channel_index_width-1:0] data_index;
  } channelizer_control_t;

  typedef struct packed {
    logic                               valid;
    logic [ecm_channel_index_width-1:0] channel_index;
    ecm_dds_mode_e                      mode;
    logic [ecm_dds_phase_width-1:0]     initial_phase;
    logic [ecm_dds_phase_width-1:0]     phase_increment;
    logic [ecm_dds_phase_width-1:0]     sweep_step;
  } ecm_dds_control_t;

endpackage

// File: rtl/ecm_dds_sin_lut.sv
// Full-wave sine ROM with two registered read ports.
// Contents are computed at elaboration:
//   rom[n] = round((2^(DATA_WIDTH-1)-1) * sin(2*pi*n/2^LUT_ADDR_WIDTH))
// Ports:
//   Clk            : clock
//   Addr_a, Addr_b : read addresses
//   Data_a, Data_b : signed samples, one cycle after the address
module ecm_dds_sin_lut
  import ecm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = ecm_dds_data_width,
  parameter int unsigned LUT_ADDR_WIDTH = ecm_dds_lut_addr_width
) (
  input  logic                           Clk,
  input  logic        [LUT_ADDR_WIDTH-1:0] Addr_a,
  input  logic        [LUT_ADDR_WIDTH-1:0] Addr_b,
  output logic signed [DATA_WIDTH-1:0]     Data_a,
  output logic signed [DATA_WIDTH-1:0]     Data_b
);

  localparam int unsigned Depth = 1 << LUT_ADDR_WIDTH;
  localparam real         Amp   = $itor((1 << (DATA_WIDTH - 1)) - 1);

  logic signed [DATA_WIDTH-1:0] rom [Depth];

  for (genvar n = 0; n < Depth; n++) begin : g_rom
    localparam real Ang = 6.283185307179586 * $itor(n) / $itor(Depth);
    localparam real Val = Amp * $sin(Ang);
    // Round half away from zero.
    localparam int  Rnd = (Val >= 0.0) ? $rtoi(Val + 0.5) : -$rtoi(0.5 - Val);
    assign rom[n] = DATA_WIDTH'(Rnd);
  end

  always_ff @(posedge Clk) begin
    Data_a <= rom[Addr_a];
    Data_b <= rom[Addr_b];
  end

endmodule

// File: rtl/ecm_dds_channel_gen.sv
// Per-channel DDS slaved to the channelizer strobe. Each accepted strobe for
// channel k emits one complex sample for k, four cycles later.
// Ports:
//   Clk, Rst         : clock, synchronous active-low reset
//   Dds_control      : channel programming (mode, phase, increment, step)
//   Channelizer_ctrl : timing strobe (valid/last/data_index)
//   Dds_ctrl         : strobe delayed by the pipeline latency
//   Dds_data         : [0] = I (cos), [1] = Q (sin), signed
// Optional build macro: ECM_DDS_PHASE_DITHER_EN adds LFSR dither below the
// LUT address bits before truncation.
// Pipeline: S0 RAM read, S1 forward/update/write-back, S2 LUT read, S3 output.
module ecm_dds_channel_gen
  import ecm_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = ecm_num_channels,
  parameter int unsigned PHASE_WIDTH    = ecm_dds_phase_width,
  parameter int unsigned LUT_ADDR_WIDTH = ecm_dds_lut_addr_width,
  parameter int unsigned DATA_WIDTH     = ecm_dds_data_width
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  ecm_dds_control_t             Dds_control,
  input  channelizer_control_t         Channelizer_ctrl,
  output channelizer_control_t         Dds_ctrl,
  output logic signed [DATA_WIDTH-1:0] Dds_data [2]
);

  localparam int unsigned AddrW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned FracW = PHASE_WIDTH - LUT_ADDR_WIDTH;
  localparam logic [LUT_ADDR_WIDTH-1:0] QuarterTurn = LUT_ADDR_WIDTH'(1 << (LUT_ADDR_WIDTH - 2));

  typedef struct packed {
    ecm_dds_mode_e          mode;
    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0] incr;
    logic [PHASE_WIDTH-1:0] step;
  } chan_state_t;

  chan_state_t ram_q [NUM_CHANNELS];

  // Post-reset clear sequencer
  logic             clr_q;
  logic [AddrW-1:0] clr_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      clr_q     <= 1'b1;
      clr_cnt_q <= '0;
    end else if (clr_q) begin
      clr_cnt_q <= clr_cnt_q + AddrW'(1);
      if (32'(clr_cnt_q) == NUM_CHANNELS - 1) clr_q <= 1'b0;
    end
  end

  // Input qualification
  logic             ctl_ok, strb_ok, strb_in_range;
  logic [AddrW-1:0] ctl_addr, strb_addr;

  assign ctl_addr      = AddrW'(Dds_control.channel_index);
  assign strb_addr     = AddrW'(Channelizer_ctrl.data_index);
  assign ctl_ok        = Dds_control.valid && !clr_q &&
                         (32'(Dds_control.channel_index) < NUM_CHANNELS);
  assign strb_in_range = 32'(Channelizer_ctrl.data_index) < NUM_CHANNELS;
  assign strb_ok       = Channelizer_ctrl.valid && !clr_q;

  // S0 registers
  logic                                s0_valid_q, s0_kill_q, s0_in_range_q, s0_last_q;
  logic [ecm_channel_index_width-1:0] s0_idx_q;
  logic [AddrW-1:0]                    s0_addr;
  chan_state_t                         s0_rd_q;

  assign s0_addr = AddrW'(s0_idx_q);

  // S1 write-back / forwarding registers
  logic        wb_valid_q;
  logic [AddrW-1:0] wb_addr_q;
  chan_state_t wb_state_q;

  chan_state_t cur, nxt;
  logic        wb_en;
  logic [PHASE_WIDTH-1:0] dither, phase_dith;

  // Control write (or clear) port, and the strobe write-back port
  logic             ctl_we;
  logic [AddrW-1:0] ctl_waddr;
  chan_state_t      ctl_wdata;

  always_comb begin
    ctl_we    = 1'b0;
    ctl_waddr = '0;
    ctl_wdata = '0;
    if (clr_q) begin
      ctl_we    = 1'b1;
      ctl_waddr = clr_cnt_q;
    end else if (ctl_ok) begin
      ctl_we          = 1'b1;
      ctl_waddr       = ctl_addr;
      ctl_wdata.mode  = Dds_control.mode;
      ctl_wdata.phase = PHASE_WIDTH'(Dds_control.initial_phase);
      ctl_wdata.incr  = PHASE_WIDTH'(Dds_control.phase_increment);
      ctl_wdata.step  = PHASE_WIDTH'(Dds_control.sweep_step);
    end
  end

  always_ff @(posedge Clk) begin
    if (wb_en) ram_q[s0_addr] <= nxt;
    // Issued second so a control write to the same entry takes precedence.
    if (ctl_we) ram_q[ctl_waddr] <= ctl_wdata;
    s0_rd_q <= ram_q[strb_addr];
  end

  // S1: a write-back landing on the same edge as our read makes the RAM
  // data stale, so take the registered write-back copy instead.
  always_comb begin
    cur = (wb_valid_q && (wb_addr_q == s0_addr)) ? wb_state_q : s0_rd_q;
    if (!s0_in_range_q) cur.mode = ecm_dds_mode_off;
    nxt = cur;
    if (cur.mode != ecm_dds_mode_off) nxt.phase = cur.phase + cur.incr;
    if (cur.mode == ecm_dds_mode_sweep) nxt.incr = cur.incr + cur.step;
  end

  // A strobe colliding with a control write to its channel reports old state
  // but must not overwrite the freshly programmed entry.
  assign wb_en = s0_valid_q && !s0_kill_q && s0_in_range_q;

`ifdef ECM_DDS_PHASE_DITHER_EN
  localparam logic [PHASE_WIDTH-1:0] FracMask = {{LUT_ADDR_WIDTH{1'b0}}, {FracW{1'b1}}};
  logic [15:0] lfsr_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      lfsr_q <= 16'hACE1;
    end else if (s0_valid_q) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign dither = PHASE_WIDTH'(lfsr_q) & FracMask;
`else
  assign dither = '0;
`endif

  assign phase_dith = cur.phase + dither;

  // S1/S2/S3 registers
  logic                                s1_valid_q, s1_last_q, s1_on_q;
  logic [ecm_channel_index_width-1:0] s1_idx_q;
  logic [LUT_ADDR_WIDTH-1:0]           s1_addr_q;
  logic                                s2_valid_q, s2_last_q, s2_on_q;
  logic [ecm_channel_index_width-1:0] s2_idx_q;
  logic signed [DATA_WIDTH-1:0]        lut_i, lut_q;
  channelizer_control_t                out_ctrl_q;
  logic signed [DATA_WIDTH-1:0]        out_i_q, out_q_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s0_valid_q     <= 1'b0;
      s0_kill_q      <= 1'b0;
      s0_in_range_q  <= 1'b0;
      s0_last_q      <= 1'b0;
      s0_idx_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_addr_q      <= '0;
      wb_state_q     <= '0;
      s1_valid_q     <= 1'b0;
      s1_last_q      <= 1'b0;
      s1_on_q        <= 1'b0;
      s1_idx_q       <= '0;
      s1_addr_q      <= '0;
      s2_valid_q     <= 1'b0;
      s2_last_q      <= 1'b0;
      s2_on_q        <= 1'b0;
      s2_idx_q       <= '0;
      out_ctrl_q     <= '0;
      out_i_q        <= '0;
      out_q_q        <= '0;
    end else begin
      s0_valid_q     <= strb_ok;
      s0_kill_q      <= ctl_ok && (Dds_control.channel_index == Channelizer_ctrl.data_index);
      s0_in_range_q  <= strb_in_range;
      s0_last_q      <= Channelizer_ctrl.last;
      s0_idx_q       <= Channelizer_ctrl.data_index;
      wb_valid_q     <= wb_en;
      wb_addr_q      <= s0_addr;
      wb_state_q     <= nxt;
      s1_valid_q     <= s0_valid_q;
      s1_last_q      <= s0_last_q;
      s1_on_q        <= cur.mode != ecm_dds_mode_off;
      s1_idx_q       <= s0_idx_q;
      s1_addr_q      <= phase_dith[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
      s2_valid_q     <= s1_valid_q;
      s2_last_q      <= s1_last_q;
      s2_on_q        <= s1_on_q;
      s2_idx_q       <= s1_idx_q;
      out_ctrl_q.valid      <= s2_valid_q;
      out_ctrl_q.last       <= s2_last_q;
      out_ctrl_q.data_index <= s2_idx_q;
      out_i_q        <= s2_on_q ? lut_i : '0;
      out_q_q        <= s2_on_q ? lut_q : '0;
    end
  end

  ecm_dds_sin_lut #(
    .DATA_WIDTH     (DATA_WIDTH),
    .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH)
  ) u_sin_lut (
    .Clk    (Clk),
    .Addr_a (s1_addr_q + QuarterTurn),
    .Addr_b (s1_addr_q),
    .Data_a (lut_i),
    .Data_b (lut_q)
  );

  assign Dds_ctrl    = out_ctrl_q;
  assign Dds_data[0] = out_i_q;
  assign Dds_data[1] = out_q_q;

endmodule

// File: doc/ecm_dds_channel_gen.md
# ecm_dds_channel_gen

Per-channel direct digital synthesizer that produces the `Dds_ctrl`/`Dds_data` stream consumed by `ecm_output_block`. It sits directly upstream of that block and is slaved to the channelizer timing strobe: each incoming sample slot for channel `k` yields one complex DDS sample for channel `k`. Each channel keeps its own phase accumulator, frequency word and optional linear sweep. Channel state is programmed through a control port.

## Interface
Parameters:
- `NUM_CHANNELS`, default `ecm_num_channels`: number of channels and depth of the state RAM.
- `PHASE_WIDTH`, default 32: width of the phase accumulator and frequency words.
- `LUT_ADDR_WIDTH`, default 12: full-wave sine LUT address width. The LUT is addressed by `phase[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH]`.
- `DATA_WIDTH`, default `ecm_dds_data_width`: output I/Q width, signed.

Ports:
- `Clk`, in, 1: clock.
- `Rst`, in, 1: synchronous, active-low.
- `Dds_control`, in, `ecm_dds_control_t`: `valid`, `channel_index`, `mode` (off/tone/sweep), `initial_phase`, `phase_increment`, `sweep_step`.
- `Channelizer_ctrl`, in, `channelizer_control_t`: timing strobe carrying `valid`, `last` and `data_index`.
- `Dds_ctrl`, out, `channelizer_control_t`: the strobe delayed by the pipeline latency.
- `Dds_data`, out, 2 x `DATA_WIDTH` signed: index 0 is I (cos), index 1 is Q (sin).

## Operation
- Channel state RAM entry: `mode`, `phase`, `increment`, `step`. After reset every entry is mode=off and all fields are 0. Clearing the RAM takes `NUM_CHANNELS` cycles; control writes and strobes arriving during the clear are ignored.
- Control write: on `Dds_control.valid`, the entry at `channel_index` is loaded with `phase=initial_phase`, `increment=phase_increment`, `step=sweep_step`, `mode=mode`.
- The write takes effect on the next strobe for that channel. That sample uses `initial_phase`.
- Sample generation, on each `Channelizer_ctrl.valid` with index `k`:
  - Read entry `k`.
  - Output the sample for the current `phase`.
  - Write back `phase += increment`, modulo 2^PHASE_WIDTH.
  - If mode=sweep, also write back `increment += step`. This is two's complement arithmetic and wraps silently.
- Output values by mode:
  - mode=tone/sweep: I = `LUT[a + 2^(LUT_ADDR_WIDTH-2)]`, Q = `LUT[a]`, where `a` is the truncated phase. Address addition wraps.
  - mode=off: I = Q = 0. The phase does not advance.
- LUT contents: `LUT[n] = round((2^(DATA_WIDTH-1)-1) * sin(2*pi*n/2^LUT_ADDR_WIDTH))`.
- Read-after-write hazard: if the same channel is strobed in two consecutive cycles, the second read takes forwarded write-back state, never stale RAM.
- Control write and strobe for the same channel in the same cycle: the strobe sample uses the old state. The control write wins the RAM write, and the strobe's write-back is discarded.
- `last` and `data_index` pass through unchanged alongside `valid`.

## Timing
- Fixed latency of 4 cycles from `Channelizer_ctrl.valid` to `Dds_ctrl.valid`:
  - S0: RAM read.
  - S1: forwarding mux and phase/increment update; write-back.
  - S2: LUT read.
  - S3: output register.
- Throughput is one strobe per cycle, with no backpressure.
- Reset values: `Dds_ctrl.valid=0`, `last=0`, `data_index=0`, `Dds_data=0`. In-flight strobes are dropped when `Rst` is asserted mid-stream, and all pipeline valids clear in the same cycle.
- `Dds_ctrl.valid` stays low throughout the post-reset clear.

## Configuration
- Macro `ECM_DDS_PHASE_DITHER_EN`.
- Defined: a 16-bit LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 0xACE1 at reset) adds its low `PHASE_WIDTH-LUT_ADDR_WIDTH` bits to the phase before truncation. The LFSR advances once per strobe.
- Undefined: plain truncation, and the output is deterministic.
- All test-plan values assume the macro is undefined.

## Structure
- `ecm_pkg` gains:
  - `ecm_dds_control_t`
  - the mode enum `ecm_dds_mode_off/tone/sweep`
  - `ecm_dds_phase_width`
  - `ecm_dds_lut_addr_width`
- Sub-module `ecm_dds_sin_lut`: dual-read-port ROM, 1-cycle registered reads, contents computed at elaboration from `DATA_WIDTH`/`LUT_ADDR_WIDTH`.

## Test plan
- **Reset:** `Rst=0` for 10 cycles, then release; drive strobes during the clear -> `Dds_ctrl.valid` never asserts; after the clear every output equals 0.
- **Quarter-turn tone:** `DATA_WIDTH=16`; ch 3, mode=tone, `initial_phase=0`, `increment=2^30`; strobe ch 3 four times.
  - Expected (I,Q): (32767,0), (0,32767), (-32767,0), (0,-32767).
  - Each sample appears 4 cycles after its strobe, with `data_index=3`.
- **Sweep:** ch 0, `increment=0`, `step=2^29`; strobe 3 times -> phases 0, 0, 2^29 -> (32767,0), (32767,0), (23170,23170).
- **Back-to-back hazard:** ch 5 tone, `increment=2^30`; strobe ch 5 on consecutive cycles -> Q = 0, 32767. A stale read would give 0, 0.
- **Collision:** ch 2 running (phase at 2^30); same-cycle control write (`initial_phase=2^31`) and ch 2 strobe -> that sample is (0,32767); the next ch 2 strobe gives (-32767,0).
- **Full sweep, off channels:** all `NUM_CHANNELS` in round-robin with odd channels off -> odd outputs are 0; `last` is high only on index `NUM_CHANNELS-1`; even channels match the reference model over 1000 rounds.
